// File: rtl/ex_forward_sb.sv
// EX-stage forwarding selects, load-use/RAW/WAW stall detection and long-op scoreboard (optional FWD_SB_STATS_EN counters).
// Latency: selects and stall are combinational from inputs and shadow state; shadows/scoreboard update on in_clk rise.
// Backpressure: out_stall holds ID/EX upstream; a stalled cycle injects a bubble into the private EX/MEM shadow.
module ex_forward_sb #(
    parameter int NUM_LANES = 2,
    parameter int NUM_REGS  = 32,
    parameter int IDX_W     = 5,
    parameter int LONG_LAT  = 10
) (
    input  logic                                       in_clk,
    input  logic                                       in_rst,
    input  logic                                       in_flush,
    input  logic [NUM_LANES-1:0]                       in_ex_valid,
    input  logic [NUM_LANES-1:0]                       in_ex_regwr,
    input  logic [NUM_LANES*IDX_W-1:0]                 in_ex_rd,
    input  logic [NUM_LANES*IDX_W-1:0]                 in_ex_rs,
    input  logic [NUM_LANES*IDX_W-1:0]                 in_ex_rt,
    input  logic [NUM_LANES-1:0]                       in_ex_use_rt,
    input  logic [NUM_LANES-1:0]                       in_ex_load,
    input  logic [NUM_LANES-1:0]                       in_ex_long,
    output logic [NUM_LANES*$clog2(2*NUM_LANES+1)-1:0] out_fwd_a,
    output logic [NUM_LANES*$clog2(2*NUM_LANES+1)-1:0] out_fwd_b,
    output logic                                       out_stall,
    output logic [NUM_REGS-1:0]                        out_sb_busy
`ifdef FWD_SB_STATS_EN
    ,
    output logic [31:0]                                out_stall_cnt,
    output logic [31:0]                                out_fwd_cnt
`endif
);
    localparam int SEL_W = $clog2(2*NUM_LANES+1);

    logic [NUM_LANES-1:0]       exm_vld_q, exm_wr_q, exm_ld_q;
    logic [NUM_LANES-1:0]       exm_vld_d, exm_wr_d, exm_ld_d;
    logic [NUM_LANES*IDX_W-1:0] exm_rd_q, exm_rd_d;
    logic [NUM_LANES-1:0]       mwb_vld_q, mwb_wr_q;
    logic [NUM_LANES-1:0]       mwb_vld_d, mwb_wr_d;
    logic [NUM_LANES*IDX_W-1:0] mwb_rd_q, mwb_rd_d;
    logic [7:0]                 sb_cnt_q [NUM_REGS];
    logic [7:0]                 sb_cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0]        busy_w;
    logic [NUM_LANES*SEL_W-1:0] fwd_a_w, fwd_b_w;
    logic                       hazard_w;

    // Later loop iterations override earlier ones: youngest lane wins, EX/MEM beats MEM/WB.
    function automatic logic [SEL_W-1:0] sel_for(
        input logic [IDX_W-1:0]           src,
        input logic [NUM_LANES-1:0]       ev,
        input logic [NUM_LANES-1:0]       ew,
        input logic [NUM_LANES*IDX_W-1:0] erd,
        input logic [NUM_LANES-1:0]       mv,
        input logic [NUM_LANES-1:0]       mw,
        input logic [NUM_LANES*IDX_W-1:0] mrd
    );
        logic [SEL_W-1:0] sel;
        sel = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (mv[l] && mw[l] && (mrd[l*IDX_W +: IDX_W] != '0) && (mrd[l*IDX_W +: IDX_W] == src))
                sel = SEL_W'(NUM_LANES + 1 + l);
        end
        for (int l = 0; l < NUM_LANES; l++) begin
            if (ev[l] && ew[l] && (erd[l*IDX_W +: IDX_W] != '0) && (erd[l*IDX_W +: IDX_W] == src))
                sel = SEL_W'(1 + l);
        end
        return sel;
    endfunction

    function automatic logic load_hit(
        input logic [IDX_W-1:0]           src,
        input logic [NUM_LANES-1:0]       ev,
        input logic [NUM_LANES-1:0]       ew,
        input logic [NUM_LANES-1:0]       el,
        input logic [NUM_LANES*IDX_W-1:0] erd
    );
        logic hit;
        hit = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (ev[l] && ew[l] && el[l] && (erd[l*IDX_W +: IDX_W] != '0) && (erd[l*IDX_W +: IDX_W] == src))
                hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        busy_w = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy_w[r] = (sb_cnt_q[r] != 8'd0);
        end
    end

    always_comb begin
        fwd_a_w  = '0;
        fwd_b_w  = '0;
        hazard_w = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            fwd_a_w[k*SEL_W +: SEL_W] = sel_for(in_ex_rs[k*IDX_W +: IDX_W], exm_vld_q, exm_wr_q, exm_rd_q,
                                                mwb_vld_q, mwb_wr_q, mwb_rd_q);
            if (in_ex_use_rt[k])
                fwd_b_w[k*SEL_W +: SEL_W] = sel_for(in_ex_rt[k*IDX_W +: IDX_W], exm_vld_q, exm_wr_q, exm_rd_q,
                                                    mwb_vld_q, mwb_wr_q, mwb_rd_q);
            if (in_ex_valid[k]) begin
                if (load_hit(in_ex_rs[k*IDX_W +: IDX_W], exm_vld_q, exm_wr_q, exm_ld_q, exm_rd_q) ||
                    busy_w[in_ex_rs[k*IDX_W +: IDX_W]])
                    hazard_w = 1'b1;
                if (in_ex_use_rt[k] &&
                    (load_hit(in_ex_rt[k*IDX_W +: IDX_W], exm_vld_q, exm_wr_q, exm_ld_q, exm_rd_q) ||
                     busy_w[in_ex_rt[k*IDX_W +: IDX_W]]))
                    hazard_w = 1'b1;
                if (in_ex_regwr[k] && busy_w[in_ex_rd[k*IDX_W +: IDX_W]])
                    hazard_w = 1'b1;
            end
        end
    end

    always_comb begin
        mwb_vld_d = exm_vld_q;
        mwb_wr_d  = exm_wr_q;
        mwb_rd_d  = exm_rd_q;
        exm_vld_d = in_ex_valid;
        exm_wr_d  = in_ex_regwr & ~in_ex_long;
        exm_ld_d  = in_ex_load;
        exm_rd_d  = in_ex_rd;
        if (in_flush) begin
            exm_vld_d = '0;
            mwb_vld_d = '0;
        end else if (hazard_w) begin
            exm_vld_d = '0;
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            sb_cnt_d[r] = (sb_cnt_q[r] != 8'd0) ? sb_cnt_q[r] - 8'd1 : 8'd0;
        end
        // An instruction killed by flush never issues, so it never reserves its destination.
        if (!hazard_w && !in_flush) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (in_ex_valid[k] && in_ex_long[k] && in_ex_regwr[k] && (in_ex_rd[k*IDX_W +: IDX_W] != '0))
                    sb_cnt_d[in_ex_rd[k*IDX_W +: IDX_W]] = 8'(LONG_LAT);
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            exm_vld_q <= '0;
            exm_wr_q  <= '0;
            exm_ld_q  <= '0;
            exm_rd_q  <= '0;
            mwb_vld_q <= '0;
            mwb_wr_q  <= '0;
            mwb_rd_q  <= '0;
            for (int r = 0; r < NUM_REGS; r++) sb_cnt_q[r] <= 8'd0;
        end else begin
            exm_vld_q <= exm_vld_d;
            exm_wr_q  <= exm_wr_d;
            exm_ld_q  <= exm_ld_d;
            exm_rd_q  <= exm_rd_d;
            mwb_vld_q <= mwb_vld_d;
            mwb_wr_q  <= mwb_wr_d;
            mwb_rd_q  <= mwb_rd_d;
            for (int r = 0; r < NUM_REGS; r++) sb_cnt_q[r] <= sb_cnt_d[r];
        end
    end

    assign out_fwd_a   = in_rst ? '0 : fwd_a_w;
    assign out_fwd_b   = in_rst ? '0 : fwd_b_w;
    assign out_stall   = in_rst ? 1'b0 : hazard_w;
    assign out_sb_busy = in_rst ? '0 : busy_w;

`ifdef FWD_SB_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (out_stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (((|out_fwd_a) || (|out_fwd_b)) && (fwd_cnt_q != 32'hFFFF_FFFF))
            fwd_cnt_d = fwd_cnt_q + 32'd1;
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign out_stall_cnt = stall_cnt_q;
    assign out_fwd_cnt   = fwd_cnt_q;
`endif

endmodule
